// File: rtl/mul_issue_seq.sv
// mul_issue_seq
// Queues 32x32 unsigned multiply requests and issues them one at a time to an
// external multiplier over a level start/finish handshake. Products come back
// with their tags, in acceptance order, through a single-entry output slot.
// Optional feature macro: MUL_ISSUE_TIMEOUT_EN adds a WAIT-state watchdog that
// returns an error result (out_err=1, out_p=0) after TIMEOUT WAIT cycles.
// Without it no counter is built and out_err is tied low.
//
// state  | meaning
// IDLE   | nothing in flight; pops the FIFO head (or takes the input directly when empty)
// ISSUE  | one cycle with mul_start=1, operands presented on mul_a/mul_b
// SETTLE | one cycle guard; mul_finish may still be high from the previous operation
// WAIT   | waiting for mul_finish together with a free output slot
module mul_issue_seq #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 80
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             mul_start,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic [63:0]      mul_p,
  input  logic             mul_finish,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_p,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Elaboration-time parameter sanity checks.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("mul_issue_seq: DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mul_issue_seq: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_SETTLE = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Operand FIFO storage (data only, no reset needed).
  logic [31:0]      mem_a   [DEPTH];
  logic [31:0]      mem_b   [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fifo_empty, fifo_full;
  logic             push, pop;

  logic [31:0]      head_a, head_b;
  logic [TAG_W-1:0] head_tag;

  // Operands and tag of the request currently in flight.
  logic [31:0]      a_q, b_q;
  logic [TAG_W-1:0] tag_q;

  logic             slot_free;
  logic             res_load;

  logic             out_valid_q;
  logic [63:0]      out_p_q;
  logic [TAG_W-1:0] out_tag_q;

`ifdef MUL_ISSUE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  // The counter holds the number of WAIT cycles already completed, so the
  // watchdog fires during the TIMEOUT-th WAIT cycle.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_hit;
  logic             res_err;
  logic             out_err_q;

  assign tmo_hit = (tmo_cnt_q == TMO_LAST);
`endif

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == FULL_CNT);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && !fifo_full;

  // When the FIFO is empty an arriving request is taken straight from the
  // input so that an idle block issues on the very next cycle.
  assign head_a   = fifo_empty ? in_a   : mem_a[rd_ptr_q];
  assign head_b   = fifo_empty ? in_b   : mem_b[rd_ptr_q];
  assign head_tag = fifo_empty ? in_tag : mem_tag[rd_ptr_q];

  assign slot_free = !out_valid_q || out_ready;

  // FIFO storage write; a bypassed request is also written, keeping the
  // pointers in step because both advance on that edge.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_q]   <= in_a;
      mem_b[wr_ptr_q]   <= in_b;
      mem_tag[wr_ptr_q] <= in_tag;
    end
  end

  // Occupancy next value: simultaneous push and pop leaves it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  // FSM next state, FIFO pop and result-load decisions.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    res_load = 1'b0;
`ifdef MUL_ISSUE_TIMEOUT_EN
    res_err   = 1'b0;
    tmo_cnt_d = tmo_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty || push) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        state_d = S_WAIT;
`ifdef MUL_ISSUE_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (mul_finish && slot_free) begin
          res_load = 1'b1;
          state_d  = S_IDLE;
        end
`ifdef MUL_ISSUE_TIMEOUT_EN
        else if (tmo_hit && !mul_finish && slot_free) begin
          res_load = 1'b1;
          res_err  = 1'b1;
          state_d  = S_IDLE;
        end else if (!tmo_hit) begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef MUL_ISSUE_TIMEOUT_EN
  // WAIT watchdog counter; saturates while a timed-out result waits for the slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`endif

  // Holding registers: captured on pop, stable through ISSUE, SETTLE and WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      tag_q <= '0;
    end else if (pop) begin
      a_q   <= head_a;
      b_q   <= head_b;
      tag_q <= head_tag;
    end
  end

  assign mul_start = (state_q == S_ISSUE);
  assign mul_a     = a_q;
  assign mul_b     = b_q;

  // Output slot: a new result wins over the drain of the current one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
      out_tag_q   <= '0;
`ifdef MUL_ISSUE_TIMEOUT_EN
      out_err_q   <= 1'b0;
`endif
    end else if (res_load) begin
      out_valid_q <= 1'b1;
      out_tag_q   <= tag_q;
`ifdef MUL_ISSUE_TIMEOUT_EN
      out_p_q     <= res_err ? '0 : mul_p;
      out_err_q   <= res_err;
`else
      out_p_q     <= mul_p;
`endif
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign out_tag   = out_tag_q;
`ifdef MUL_ISSUE_TIMEOUT_EN
  assign out_err   = out_err_q;
`else
  assign out_err   = 1'b0;
`endif

endmodule
